// File: rtl/phy_regfile_read_stage_pkg.sv
// Shared types and constants for the decode-to-physical-regfile read stage.
package phy_regfile_read_stage_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned PHY_REG_NUM = 64;
    localparam int unsigned TAG_W       = $clog2(PHY_REG_NUM);
    localparam int unsigned PC_W        = 32;
    localparam int unsigned IMM_W       = 32;
    localparam int unsigned NUM_WB      = 2;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] fu_sel;
        logic       use_imm;
        logic       is_branch;
    } control_t;

    typedef struct packed {
        control_t              ctrl;
        logic [PC_W-1:0]       pc;
        logic [TAG_W-1:0]      rs1;
        logic [TAG_W-1:0]      rs2;
        logic [TAG_W-1:0]      rd;
        logic [IMM_W-1:0]      imm;
        logic [DATA_WIDTH-1:0] src1_data;
        logic [DATA_WIDTH-1:0] src2_data;
        logic                  src1_rdy;
        logic                  src2_rdy;
    } rf_entry_t;

endpackage

// File: rtl/phy_regfile_skid_buf.sv
// Two-entry buffer (output register + skid entry) with in-place operand wakeup and flush.
module phy_regfile_skid_buf
    import phy_regfile_read_stage_pkg::*;
#(
    parameter int unsigned WB_PORTS = NUM_WB
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_flush,
    input  logic                           i_push,
    input  rf_entry_t                      i_entry,
    input  logic                           i_pop,
    input  logic [WB_PORTS-1:0]            i_wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]      i_wb_tag,
    input  logic [WB_PORTS*DATA_WIDTH-1:0] i_wb_data,
    output rf_entry_t                      o_head,
    output logic                           o_valid,
    output logic                           o_full
);

    rf_entry_t r_head;
    rf_entry_t r_skid;
    logic      r_head_v;
    logic      r_skid_v;
    rf_entry_t w_head_woken;
    rf_entry_t w_skid_woken;

    function automatic rf_entry_t wake(input rf_entry_t e,
                                       input logic [WB_PORTS-1:0] v,
                                       input logic [WB_PORTS*TAG_W-1:0] t,
                                       input logic [WB_PORTS*DATA_WIDTH-1:0] d);
        rf_entry_t r;
        r = e;
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (v[p] && !e.src1_rdy && t[p*TAG_W +: TAG_W] == e.rs1) begin
                r.src1_data = d[p*DATA_WIDTH +: DATA_WIDTH];
                r.src1_rdy  = 1'b1;
            end
            if (v[p] && !e.src2_rdy && t[p*TAG_W +: TAG_W] == e.rs2) begin
                r.src2_data = d[p*DATA_WIDTH +: DATA_WIDTH];
                r.src2_rdy  = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        w_head_woken = wake(r_head, i_wb_valid, i_wb_tag, i_wb_data);
        w_skid_woken = wake(r_skid, i_wb_valid, i_wb_tag, i_wb_data);
    end

    // Push only arrives while the skid entry is empty, so a pop with a full skid never sees a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head   <= '0;
            r_skid   <= '0;
            r_head_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (i_flush) begin
            r_head_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (!r_head_v) begin
            if (i_push) begin
                r_head   <= i_entry;
                r_head_v <= 1'b1;
            end
        end else if (i_pop) begin
            if (r_skid_v) begin
                r_head   <= w_skid_woken;
                r_skid_v <= 1'b0;
            end else if (i_push) begin
                r_head <= i_entry;
            end else begin
                r_head_v <= 1'b0;
            end
        end else begin
            r_head <= w_head_woken;
            if (r_skid_v) begin
                r_skid <= w_skid_woken;
            end else if (i_push) begin
                r_skid   <= i_entry;
                r_skid_v <= 1'b1;
            end
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_head_v;
    assign o_full  = r_skid_v;

endmodule

// File: rtl/phy_regfile_read_stage.sv
// Physical regfile + ready scoreboard read stage feeding the issue stage through a skid buffer.
module phy_regfile_read_stage
    import phy_regfile_read_stage_pkg::*;
#(
    parameter int unsigned WB_PORTS = NUM_WB
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  control_t                       in_control,
    input  logic [PC_W-1:0]                in_pc,
    input  logic [TAG_W-1:0]               in_rs1,
    input  logic [TAG_W-1:0]               in_rs2,
    input  logic [TAG_W-1:0]               in_rd,
    input  logic [IMM_W-1:0]               in_imm,
    input  logic [WB_PORTS-1:0]            wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]      wb_tag,
    input  logic [WB_PORTS*DATA_WIDTH-1:0] wb_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output control_t                       out_control,
    output logic [PC_W-1:0]                out_pc,
    output logic [IMM_W-1:0]               out_imm,
    output logic [TAG_W-1:0]               out_rs1,
    output logic [TAG_W-1:0]               out_rs2,
    output logic [TAG_W-1:0]               out_rd,
    output logic [DATA_WIDTH-1:0]          out_src1_data,
    output logic [DATA_WIDTH-1:0]          out_src2_data,
    output logic                           out_src1_rdy,
    output logic                           out_src2_rdy
);

    logic [DATA_WIDTH-1:0] r_regfile [PHY_REG_NUM];
    logic [PHY_REG_NUM-1:0] r_sb;
    logic      w_full;
    logic      w_accept;
    rf_entry_t w_entry;
    rf_entry_t w_head;

    assign in_ready = !w_full;
    assign w_accept = in_valid && in_ready && !flush;

    // p0 is never written nor cleared, so a plain array read already yields 0 / ready for it.
    always_comb begin
        w_entry           = '0;
        w_entry.ctrl      = in_control;
        w_entry.pc        = in_pc;
        w_entry.rs1       = in_rs1;
        w_entry.rs2       = in_rs2;
        w_entry.rd        = in_rd;
        w_entry.imm       = in_imm;
        w_entry.src1_data = r_regfile[in_rs1];
        w_entry.src1_rdy  = r_sb[in_rs1];
        w_entry.src2_data = r_regfile[in_rs2];
        w_entry.src2_rdy  = r_sb[in_rs2];
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && in_rs1 != '0 && wb_tag[p*TAG_W +: TAG_W] == in_rs1) begin
                w_entry.src1_data = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                w_entry.src1_rdy  = 1'b1;
            end
            if (wb_valid[p] && in_rs2 != '0 && wb_tag[p*TAG_W +: TAG_W] == in_rs2) begin
                w_entry.src2_data = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                w_entry.src2_rdy  = 1'b1;
            end
        end
    end

    // Accept clear is applied after the writeback sets so it wins on a tag collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < PHY_REG_NUM; i++) begin
                r_regfile[i] <= '0;
            end
            r_sb <= '1;
        end else begin
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] != '0) begin
                    r_regfile[wb_tag[p*TAG_W +: TAG_W]] <= wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                    r_sb[wb_tag[p*TAG_W +: TAG_W]]      <= 1'b1;
                end
            end
            if (w_accept && in_rd != '0) begin
                r_sb[in_rd] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned a = 0; a < WB_PORTS; a++) begin
            for (int unsigned b = a + 1; b < WB_PORTS; b++) begin
                if (reset && wb_valid[a] && wb_valid[b]) begin
                    assert (wb_tag[a*TAG_W +: TAG_W] != wb_tag[b*TAG_W +: TAG_W]);
                end
            end
        end
    end

    phy_regfile_skid_buf #(
        .WB_PORTS (WB_PORTS)
    ) u_skid (
        .clk        (clk),
        .rst_n      (reset),
        .i_flush    (flush),
        .i_push     (w_accept),
        .i_entry    (w_entry),
        .i_pop      (out_ready),
        .i_wb_valid (wb_valid),
        .i_wb_tag   (wb_tag),
        .i_wb_data  (wb_data),
        .o_head     (w_head),
        .o_valid    (out_valid),
        .o_full     (w_full)
    );

    assign out_control   = w_head.ctrl;
    assign out_pc        = w_head.pc;
    assign out_imm       = w_head.imm;
    assign out_rs1       = w_head.rs1;
    assign out_rs2       = w_head.rs2;
    assign out_rd        = w_head.rd;
    assign out_src1_data = w_head.src1_data;
    assign out_src2_data = w_head.src2_data;
    assign out_src1_rdy  = w_head.src1_rdy;
    assign out_src2_rdy  = w_head.src2_rdy;

endmodule

// File: tb/tb_phy_regfile_read_stage.sv
// Directed + randomized bench for phy_regfile_read_stage against a queue-based reference model.
module tb_phy_regfile_read_stage;
    import phy_regfile_read_stage_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    control_t                  in_control;
    logic [PC_W-1:0]           in_pc;
    logic [TAG_W-1:0]          in_rs1, in_rs2, in_rd;
    logic [IMM_W-1:0]          in_imm;
    logic [NUM_WB-1:0]         wb_valid;
    logic [NUM_WB*TAG_W-1:0]   wb_tag;
    logic [NUM_WB*DATA_WIDTH-1:0] wb_data;
    logic                      out_valid;
    logic                      out_ready;
    control_t                  out_control;
    logic [PC_W-1:0]           out_pc;
    logic [IMM_W-1:0]          out_imm;
    logic [TAG_W-1:0]          out_rs1, out_rs2, out_rd;
    logic [DATA_WIDTH-1:0]     out_src1_data, out_src2_data;
    logic                      out_src1_rdy, out_src2_rdy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state: architectural view of the regfile/scoreboard and in-flight queue.
    logic [DATA_WIDTH-1:0] m_rf [PHY_REG_NUM];
    logic                  m_sb [PHY_REG_NUM];
    rf_entry_t             q[$];
    logic [PC_W-1:0]       obs_pc[$];

    always #5 clk = ~clk;

    phy_regfile_read_stage #(.WB_PORTS(NUM_WB)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_control(in_control),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_control(out_control),
        .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_src1_data(out_src1_data), .out_src2_data(out_src2_data),
        .out_src1_rdy(out_src1_rdy), .out_src2_rdy(out_src2_rdy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PHY_REG_NUM; i++) begin
            m_rf[i] = '0;
            m_sb[i] = 1'b1;
        end
        q.delete();
    endtask

    task automatic mread(input logic [TAG_W-1:0] t, output logic [DATA_WIDTH-1:0] d, output logic r);
        d = m_rf[t];
        r = m_sb[t];
        if (t != 0) begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] == t) begin
                    d = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                    r = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        wb_valid = '0;
        wb_tag   = '0;
        wb_data  = '0;
    endtask

    task automatic inst(input logic [TAG_W-1:0] rs1, input logic [TAG_W-1:0] rs2,
                        input logic [TAG_W-1:0] rd, input logic [PC_W-1:0] pc);
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_pc      = pc;
        in_control = control_t'($urandom_range(0, 255));
        in_imm     = $urandom;
    endtask

    task automatic wb1(input int p, input logic [TAG_W-1:0] t, input logic [DATA_WIDTH-1:0] d);
        wb_valid[p] = 1'b1;
        wb_tag[p*TAG_W +: TAG_W] = t;
        wb_data[p*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    // One clock: advance the model from pre-edge inputs, clock the DUT, then compare.
    task automatic cycle(output bit acc);
        rf_entry_t ne;
        int unsigned n;
        n = q.size();
        acc = in_valid && (n < 2) && !flush;
        if (out_valid && out_ready) obs_pc.push_back(out_pc);
        ne = '0;
        ne.ctrl = in_control; ne.pc = in_pc; ne.imm = in_imm;
        ne.rs1 = in_rs1; ne.rs2 = in_rs2; ne.rd = in_rd;
        mread(in_rs1, ne.src1_data, ne.src1_rdy);
        mread(in_rs2, ne.src2_data, ne.src2_rdy);
        foreach (q[i]) begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && !q[i].src1_rdy && wb_tag[p*TAG_W +: TAG_W] == q[i].rs1) begin
                    q[i].src1_data = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                    q[i].src1_rdy  = 1'b1;
                end
                if (wb_valid[p] && !q[i].src2_rdy && wb_tag[p*TAG_W +: TAG_W] == q[i].rs2) begin
                    q[i].src2_data = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                    q[i].src2_rdy  = 1'b1;
                end
            end
        end
        if (n > 0 && out_ready) void'(q.pop_front());
        if (flush) q.delete();
        if (acc) q.push_back(ne);
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] != 0) begin
                m_rf[wb_tag[p*TAG_W +: TAG_W]] = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                m_sb[wb_tag[p*TAG_W +: TAG_W]] = 1'b1;
            end
        end
        if (acc && in_rd != 0) m_sb[in_rd] = 1'b0;
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            check("out_control", 64'(out_control), 64'(q[0].ctrl));
            check("out_pc", 64'(out_pc), 64'(q[0].pc));
            check("out_imm", 64'(out_imm), 64'(q[0].imm));
            check("out_tags", 64'({out_rs1, out_rs2, out_rd}), 64'({q[0].rs1, q[0].rs2, q[0].rd}));
            check("src1_data", 64'(out_src1_data), 64'(q[0].src1_data));
            check("src1_rdy", 64'(out_src1_rdy), 64'(q[0].src1_rdy));
            check("src2_data", 64'(out_src2_data), 64'(q[0].src2_data));
            check("src2_rdy", 64'(out_src2_rdy), 64'(q[0].src2_rdy));
        end
    endtask

    initial begin
        bit acc;
        int unsigned k;
        logic [TAG_W-1:0] t0, t1;
        idle();
        out_ready = 1'b1;
        in_control = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_src1", 64'({out_src1_data, out_src1_rdy}), 64'd0);
        reset = 1'b1;

        // 1: p5 = 0x11, then read p5/p0 writing p7
        wb1(0, 6'd5, 32'h11); cycle(acc); idle();
        inst(6'd5, 6'd0, 6'd7, 32'h100); cycle(acc); idle();
        check("t1_src1", 64'({out_src1_data, out_src1_rdy}), 64'h23);
        check("t1_src2", 64'({out_src2_data, out_src2_rdy}), 64'h1);
        cycle(acc);

        // 2: p7 not ready, held with out_ready low, woken two cycles later
        out_ready = 1'b0;
        inst(6'd7, 6'd0, 6'd8, 32'h104); cycle(acc); idle();
        check("t2_rdy0", 64'(out_src1_rdy), 64'd0);
        cycle(acc);
        wb1(1, 6'd7, 32'hAB); cycle(acc); idle();
        check("t2_wake", 64'({out_src1_data, out_src1_rdy}), 64'h157);
        check("t2_pc", 64'(out_pc), 64'h104);
        out_ready = 1'b1; cycle(acc);

        // 3: bypass on accept
        inst(6'd0, 6'd0, 6'd9, 32'h108); cycle(acc);
        inst(6'd0, 6'd9, 6'd10, 32'h10C); wb1(0, 6'd9, 32'h55); cycle(acc); idle();
        check("t3_bypass", 64'({out_src2_data, out_src2_rdy}), 64'hAB);
        cycle(acc);

        // 4: four back-to-back with stalled output
        obs_pc.delete();
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 4) begin
                check("t4_full", 64'(in_ready), 64'd0);
                check("t4_accepts", 64'(k), 64'd2);
                out_ready = 1'b1;
            end
            if (k < 4) inst(6'd0, 6'd0, 6'd0, 32'h400 + 32'(k * 4));
            else idle();
            cycle(acc);
            if (acc) k++;
        end
        check("t4_count", 64'(obs_pc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_pc.size()) check("t4_order", 64'(obs_pc[i]), 64'h400 + 64'(i * 4));
        end
        idle();

        // 5: flush with full buffer, accept and writeback in the same cycle
        out_ready = 1'b0;
        inst(6'd0, 6'd0, 6'd11, 32'h200); cycle(acc);
        inst(6'd0, 6'd0, 6'd12, 32'h204); cycle(acc);
        flush = 1'b1; inst(6'd0, 6'd0, 6'd13, 32'h208); wb1(0, 6'd3, 32'h9); cycle(acc); idle();
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        inst(6'd3, 6'd0, 6'd0, 32'h20C); cycle(acc); idle();
        check("t5_rf3", 64'({out_src1_data, out_src1_rdy}), 64'h13);

        // 6: clear beats writeback; p0 stays zero
        inst(6'd0, 6'd0, 6'd4, 32'h300); wb1(1, 6'd4, 32'h77); cycle(acc); idle();
        inst(6'd4, 6'd0, 6'd0, 32'h304); wb1(0, 6'd0, 32'hFF); cycle(acc); idle();
        check("t6_clear", 64'(out_src1_rdy), 64'd0);
        inst(6'd0, 6'd0, 6'd0, 32'h308); cycle(acc); idle();
        check("t6_p0", 64'({out_src1_data, out_src1_rdy}), 64'h1);
        cycle(acc);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 2) != 0)
                inst(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                     6'($urandom_range(0, 15)), $urandom);
            t0 = 6'($urandom_range(0, 15));
            t1 = 6'($urandom_range(0, 15));
            if (t1 == t0) t1 = t0 ^ 6'd1;
            if ($urandom_range(0, 1) != 0) wb1(0, t0, $urandom);
            if ($urandom_range(0, 1) != 0) wb1(1, t1, $urandom);
            cycle(acc);
        end

        // Asynchronous reset in the middle of traffic
        idle();
        out_ready = 1'b0;
        inst(6'd1, 6'd2, 6'd3, 32'h500); cycle(acc); idle();
        #2 reset = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_ready", 64'(in_ready), 64'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        inst(6'd3, 6'd0, 6'd5, 32'h600); cycle(acc); idle();
        cycle(acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
